axi_stream_packet_arbiter: RTL and testbench
============================================

# axi_stream_packet_arbiter

Two-input, packet-granular round-robin arbiter that merges two AXI-stream sources into one AXI-stream sink. A grant is held from the first beat of a packet through its `tlast` beat, so packets are never interleaved. The output is registered through a one-entry slice, so the sink side always satisfies the sender-stability rule. It sits in front of shared stream consumers in the compressor datapath, for example two producers feeding one encoder or output FIFO.

## Interface
- `DWIDTH`, 32: data width in bits; `tkeep` width is `DWIDTH/8`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s0_tvalid`, `s1_tvalid`  in  1 each  source valid.
- `s0_tready`, `s1_tready`  out  1 each  source ready.
- `s0_tdata`, `s1_tdata`  in  DWIDTH each  source data.
- `s0_tlast`, `s1_tlast`  in  1 each  end-of-packet marker.
- `s0_tkeep`, `s1_tkeep`  in  DWIDTH/8 each  byte enables.
- `m_tready`  in  1  sink ready.
- `m_tvalid`  out  1  sink valid.
- `m_tdata`  out  DWIDTH  sink data.
- `m_tlast`  out  1  sink end-of-packet marker.
- `m_tkeep`  out  DWIDTH/8  sink byte enables.
- `m_tid`  out  1  source index of the current `m_*` beat.

## Operation
- State machine with two states, IDLE and LOCK. Registers:
  - `grant` (1 bit): port that owns the output.
  - `rr_last` (1 bit): port of the last completed packet.
  - Output slice: `m_tvalid`, `m_tdata`, `m_tlast`, `m_tkeep`, `m_tid`.
- IDLE:
  - All `sN_tready` = 0.
  - Neither port valid: stay in IDLE.
  - Exactly one port valid: `grant` <= that port; go to LOCK.
  - Both ports valid: `grant` <= `~rr_last`; go to LOCK.
- LOCK:
  - `s[grant]_tready` = `~m_tvalid | m_tready`. The other port's `tready` = 0.
  - `tready` never depends on any `tvalid`, so there are no combinational loops.
- Source handshake (`s[grant]_tvalid & s[grant]_tready`):
  - Load `tdata`, `tlast` and `tkeep` into the slice.
  - `m_tid` <= `grant`; `m_tvalid` <= 1.
  - If `tlast` = 1: `rr_last` <= `grant`; go to IDLE.
- Sink side:
  - `m_tready & m_tvalid` with no new load in the same cycle: `m_tvalid` <= 0.
  - Load and drain in the same cycle: the slice is overwritten and `m_tvalid` stays 1.
  - While `m_tvalid & ~m_tready`: all `m_*` outputs hold unchanged and `m_tvalid` is never withdrawn.
- `tdata`, `tkeep` and `tlast` are passed bit-exact. No width change, no beat merging, no beat dropping.
- Source protocol violations (valid withdrawn, data changed while stalled) are not detected. The source must keep AXI-stream ordering.
- Reset, including mid-packet:
  - State goes to IDLE; `grant` = 0; `rr_last` = 1, so port 0 wins the first tie.
  - Outputs: `m_tvalid` = 0, `m_tdata` = 0, `m_tlast` = 0, `m_tkeep` = 0, `m_tid` = 0.
  - A partially transferred packet is truncated. No recovery or `tlast` is emitted.

## Timing
- Arbitration takes 1 cycle:
  - Cycle 0: `tvalid` is seen in IDLE.
  - Cycle 1: LOCK, and `s_tready` is high if the slice is free.
  - Cycle 2: the first beat appears on `m_*`.
- Input-to-output latency is 1 cycle per beat once locked.
- With `m_tready` held at 1 and the source always valid, throughput is 1 beat per cycle within a packet.
- Each packet costs one bubble cycle, the IDLE cycle after its `tlast` handshake.
- Consecutive packets from two always-valid sources alternate 0,1,0,1,…
- A single-beat packet (first beat has `tlast` = 1) returns to IDLE in the same cycle as its handshake.

## Test plan
- Single packet on port 0, `m_tready`=1: `s0` drives 3 beats with data 0x11, 0x22, 0x33, `tkeep`=0xF, `tlast` on the third beat. Required: the same beats appear on `m_*` starting 2 cycles after `s0_tvalid` rises, one per cycle, with `m_tid`=0. `s1_tready` stays 0 throughout.
- Tie after reset: both ports present 2-beat packets in the same cycle. Required:
  - Port 0 is granted first, then port 1.
  - Output beat order is p0b0, p0b1, p1b0, p1b1, with one bubble cycle between the packets.
  - `m_tid` reads 0,0,1,1.
- Fairness: both ports stream 4 single-beat packets each. Required: `m_tid` sequence is 0,1,0,1,0,1,0,1 and no packet is lost.
- Sink backpressure: `m_tready` toggles pseudo-randomly. Required:
  - An AXI-stream stability checker instantiated on the `m_*` bus reports no error.
  - Every beat is delivered exactly once, in order.
- No interleave: port 0 sends a 5-beat packet while port 1 becomes valid at beat 2. Required:
  - `s1_tready` stays 0 until the cycle after port 0's `tlast` handshake, and `s1_tready` = 1 one cycle after that.
  - Port 1's packet follows port 0's packet contiguously.
- Reset mid-packet: assert `rst` for 1 cycle during beat 2 of a 4-beat packet while `m_tvalid`=1. Required:
  - Next cycle, `m_tvalid`, `s0_tready` and `s1_tready` are all 0.
  - A subsequent tie grants port 0.

Source files
------------

// File: rtl/axi_stream_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_packet_arbiter
// Brief    : Two-input, packet-granular round-robin AXI-stream arbiter.
//            A grant is held from the first beat of a packet through its
//            tlast beat, so packets from the two sources never interleave.
//            The sink side is driven from a one-entry register slice.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            s0_* / s1_*         - source streams (tvalid, tready, tdata,
//                                  tlast, tkeep)
//            m_*                 - merged sink stream (tvalid, tready, tdata,
//                                  tlast, tkeep) plus m_tid = source index
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_packet_arbiter #(
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DWIDTH-1:0]     s0_tdata,
    input  logic                  s0_tlast,
    input  logic [DWIDTH/8-1:0]   s0_tkeep,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic [DWIDTH-1:0]     s1_tdata,
    input  logic                  s1_tlast,
    input  logic [DWIDTH/8-1:0]   s1_tkeep,
    input  logic                  m_tready,
    output logic                  m_tvalid,
    output logic [DWIDTH-1:0]     m_tdata,
    output logic                  m_tlast,
    output logic [DWIDTH/8-1:0]   m_tkeep,
    output logic                  m_tid
);

    localparam int         c_KWIDTH  = DWIDTH / 8;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_LOCK = 1'b1;

    logic [0:0]          r_state;
    logic                r_grant;
    logic                r_rr_last;
    logic                r_m_tvalid;
    logic [DWIDTH-1:0]   r_m_tdata;
    logic                r_m_tlast;
    logic [c_KWIDTH-1:0] r_m_tkeep;
    logic                r_m_tid;

    logic                w_slice_free;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DWIDTH-1:0]   w_sel_data;
    logic [c_KWIDTH-1:0] w_sel_keep;
    logic                w_load;

    // Ready is a function of registered state and m_tready only; it never
    // looks at any tvalid, which keeps the source handshake loop-free.
    assign w_slice_free = (r_state == c_ST_LOCK) && (!r_m_tvalid || m_tready);
    assign s0_tready    = w_slice_free && !r_grant;
    assign s1_tready    = w_slice_free &&  r_grant;

    // Mux of the granted source.
    assign w_sel_valid  = r_grant ? s1_tvalid : s0_tvalid;
    assign w_sel_last   = r_grant ? s1_tlast  : s0_tlast;
    assign w_sel_data   = r_grant ? s1_tdata  : s0_tdata;
    assign w_sel_keep   = r_grant ? s1_tkeep  : s0_tkeep;
    assign w_load       = w_slice_free && w_sel_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_grant    <= 1'b0;
            // Pretend port 1 finished last so port 0 wins the first tie.
            r_rr_last  <= 1'b1;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tkeep  <= '0;
            r_m_tid    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (s0_tvalid && s1_tvalid) begin
                        r_grant <= ~r_rr_last;
                        r_state <= c_ST_LOCK;
                    end else if (s0_tvalid) begin
                        r_grant <= 1'b0;
                        r_state <= c_ST_LOCK;
                    end else if (s1_tvalid) begin
                        r_grant <= 1'b1;
                        r_state <= c_ST_LOCK;
                    end
                end
                c_ST_LOCK: begin
                    // Release the grant on the tlast handshake; the next
                    // cycle is the arbitration bubble.
                    if (w_load && w_sel_last) begin
                        r_rr_last <= r_grant;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            // Output slice: a new load wins over a drain in the same cycle,
            // and the slice holds while the sink stalls.
            if (w_load) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_sel_data;
                r_m_tlast  <= w_sel_last;
                r_m_tkeep  <= w_sel_keep;
                r_m_tid    <= r_grant;
            end else if (r_m_tvalid && m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_tlast  = r_m_tlast;
    assign m_tkeep  = r_m_tkeep;
    assign m_tid    = r_m_tid;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_packet_arbiter
// Brief    : Self-checking bench for axi_stream_packet_arbiter. Source
//            handshakes feed per-port expected-beat queues; a monitor pops
//            and compares each delivered sink beat, checks sink stability
//            under backpressure and packet atomicity, and logs packet order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_packet_arbiter;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int TMO = 5000;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [1:0]    svalid;
    logic [1:0]    slast;
    logic [DW-1:0] sdata [2];
    logic [KW-1:0] skeep [2];
    wire  [1:0]    w_sready;
    logic          m_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic [KW-1:0] m_tkeep;
    logic          m_tid;

    axi_stream_packet_arbiter #(.DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s0_tvalid (svalid[0]),
        .s0_tready (w_sready[0]),
        .s0_tdata  (sdata[0]),
        .s0_tlast  (slast[0]),
        .s0_tkeep  (skeep[0]),
        .s1_tvalid (svalid[1]),
        .s1_tready (w_sready[1]),
        .s1_tdata  (sdata[1]),
        .s1_tlast  (slast[1]),
        .s1_tkeep  (skeep[1]),
        .m_tready  (m_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tkeep   (m_tkeep),
        .m_tid     (m_tid)
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    bp_en = 0;
    beat_t exp_q0 [$];
    beat_t exp_q1 [$];
    int    tid_log [$];
    int    beat_cyc [$];
    bit    in_pkt = 0;
    bit    cur_tid = 0;
    bit    prev_stall = 0;
    logic [DW+KW+2:0] prev_snap;
    bit    seen_rdy1 = 0;
    int    first_rdy1 = -1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sink ready: constant 1 or pseudo-random when backpressure is enabled.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        beat_t e;
        logic [DW+KW+2:0] snap;
        snap = {m_tvalid, m_tdata, m_tlast, m_tkeep, m_tid};
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            in_pkt     = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("sink_stable", 64'(snap), 64'(prev_snap));
            if (m_tvalid && m_tready) begin
                beat_cyc.push_back(cyc);
                if (in_pkt) chk("no_interleave_tid", 64'(m_tid), 64'(cur_tid));
                if ((m_tid ? exp_q1.size() : exp_q0.size()) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got tid=%0d data=%0h expected no beat", m_tid, m_tdata);
                end else begin
                    e = m_tid ? exp_q1.pop_front() : exp_q0.pop_front();
                    chk("beat_data", 64'(m_tdata), 64'(e.d));
                    chk("beat_keep", 64'(m_tkeep), 64'(e.k));
                    chk("beat_last", 64'(m_tlast), 64'(e.l));
                end
                if (m_tlast) begin
                    in_pkt = 0;
                    tid_log.push_back(int'(m_tid));
                end else begin
                    in_pkt  = 1;
                    cur_tid = m_tid;
                end
            end
            if (svalid[0] && w_sready[0]) exp_q0.push_back({sdata[0], skeep[0], slast[0]});
            if (svalid[1] && w_sready[1]) exp_q1.push_back({sdata[1], skeep[1], slast[1]});
            if (w_sready[1]) begin
                seen_rdy1 = 1;
                if (first_rdy1 < 0) first_rdy1 = cyc;
            end
            prev_stall = m_tvalid && !m_tready;
        end
        prev_snap = snap;
    end

    // Drive one packet of n beats on port p; directed data is p<<8 | 0x11*(i+1).
    task automatic send_pkt(input int p, input int n, input int gap_max, input bit rnd);
        int w;
        for (int i = 0; i < n; i++) begin
            sdata[p]  = rnd ? DW'($urandom) : ((DW'(p) << 8) | (DW'(32'h11) * DW'(i + 1)));
            skeep[p]  = rnd ? KW'($urandom_range(1, 15)) : {KW{1'b1}};
            slast[p]  = (i == n - 1);
            svalid[p] = 1'b1;
            w = 0;
            @(negedge clk);
            while (!w_sready[p] && w < TMO) begin
                @(negedge clk);
                w++;
            end
            if (w >= TMO) begin
                total++;
                bad++;
                $display("FAIL src%0d_handshake_timeout: got no tready expected tready within %0d cycles", p, TMO);
                svalid[p] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            svalid[p] = 1'b0;
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || m_tvalid) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_beats", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        tid_log.delete();
        beat_cyc.delete();
        seen_rdy1  = 0;
        first_rdy1 = -1;
    endtask

    initial begin
        int t0;
        rst      = 1'b1;
        svalid   = '0;
        slast    = '0;
        sdata[0] = '0;
        sdata[1] = '0;
        skeep[0] = '0;
        skeep[1] = '0;

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_m_tid", 64'(m_tid), 64'd0);
        chk("rst_s_tready", 64'(w_sready), 64'd0);

        // Single 3-beat packet on port 0.
        @(posedge clk);
        #1;
        clear_logs();
        t0 = cyc;
        send_pkt(0, 3, 0, 1'b0);
        wait_drain();
        chk("t1_beat_count", 64'(beat_cyc.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < beat_cyc.size()) chk("t1_beat_cycle", 64'(beat_cyc[i] - t0), 64'(i + 2));
        chk("t1_pkt_count", 64'(tid_log.size()), 64'd1);
        if (tid_log.size() > 0) chk("t1_tid", 64'(tid_log[0]), 64'd0);
        chk("t1_s1_ready_never", 64'(seen_rdy1), 64'd0);

        // Tie after reset.
        do_reset();
        clear_logs();
        t0 = cyc;
        fork
            send_pkt(0, 2, 0, 1'b0);
            send_pkt(1, 2, 0, 1'b0);
        join
        wait_drain();
        chk("t2_pkt_count", 64'(tid_log.size()), 64'd2);
        if (tid_log.size() == 2) begin
            chk("t2_first_tid", 64'(tid_log[0]), 64'd0);
            chk("t2_second_tid", 64'(tid_log[1]), 64'd1);
        end
        chk("t2_beat_count", 64'(beat_cyc.size()), 64'd4);
        if (beat_cyc.size() == 4) begin
            chk("t2_p0b0_cycle", 64'(beat_cyc[0] - t0), 64'd2);
            chk("t2_p0b1_cycle", 64'(beat_cyc[1] - t0), 64'd3);
            chk("t2_p1b0_cycle", 64'(beat_cyc[2] - t0), 64'd5);
            chk("t2_p1b1_cycle", 64'(beat_cyc[3] - t0), 64'd6);
        end

        // Fairness: 4 single-beat packets per port, sources always valid.
        do_reset();
        clear_logs();
        fork
            repeat (4) send_pkt(0, 1, 0, 1'b1);
            repeat (4) send_pkt(1, 1, 0, 1'b1);
        join
        wait_drain();
        chk("t3_pkt_count", 64'(tid_log.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < tid_log.size()) chk("t3_tid_order", 64'(tid_log[i]), 64'(i % 2));

        // No interleave: port 1 becomes valid at port 0's beat 2.
        do_reset();
        clear_logs();
        t0 = cyc;
        fork
            send_pkt(0, 5, 0, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                send_pkt(1, 2, 0, 1'b0);
            end
        join
        wait_drain();
        chk("t4_s1_first_ready_cycle", 64'(first_rdy1 - t0), 64'd7);
        chk("t4_pkt_count", 64'(tid_log.size()), 64'd2);
        if (tid_log.size() == 2) begin
            chk("t4_first_tid", 64'(tid_log[0]), 64'd0);
            chk("t4_second_tid", 64'(tid_log[1]), 64'd1);
        end
        if (beat_cyc.size() == 7) chk("t4_p1_first_beat_cycle", 64'(beat_cyc[5] - t0), 64'd8);
        else chk("t4_beat_count", 64'(beat_cyc.size()), 64'd7);

        // Reset in the middle of a 4-beat packet.
        do_reset();
        clear_logs();
        @(posedge clk);
        #1;
        sdata[0]  = 32'hA0;
        skeep[0]  = 4'hF;
        slast[0]  = 1'b0;
        svalid[0] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sdata[0] = 32'hA1;
        chk("t5_pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        svalid[0] = 1'b0;
        @(negedge clk);
        chk("t5_post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t5_post_rst_s_tready", 64'(w_sready), 64'd0);
        @(posedge clk);
        #1;
        clear_logs();
        fork
            send_pkt(0, 1, 0, 1'b1);
            send_pkt(1, 1, 0, 1'b1);
        join
        wait_drain();
        chk("t5_pkt_count", 64'(tid_log.size()), 64'd2);
        if (tid_log.size() == 2) chk("t5_tie_first_tid", 64'(tid_log[0]), 64'd0);

        // Random packets with random sink backpressure.
        do_reset();
        clear_logs();
        bp_en = 1;
        fork
            repeat (40) send_pkt(0, $urandom_range(1, 6), 3, 1'b1);
            repeat (40) send_pkt(1, $urandom_range(1, 6), 3, 1'b1);
        join
        bp_en = 0;
        wait_drain();
        chk("t6_pkt_count", 64'(tid_log.size()), 64'd80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
